// File: rtl/pingpong_pkg.sv
// Shared types and sizing helpers for the ping-pong write scheduler.
package pingpong_pkg;

  // Life cycle of one FIFO bank as seen from the write side.
  typedef enum logic [1:0] {
    BankFree     = 2'd0,  // empty and drained, may start filling
    BankFilling  = 2'd1,  // holds 1..DEPTH-1 words, still accepting
    BankSealedNe = 2'd2,  // sealed, waiting to see the reader's empty flag drop
    BankSealed   = 2'd3   // sealed, waiting for the reader to finish draining
  } bank_state_e;

  localparam int unsigned NumBanks = 2;

  // Words per bank for a given FIFO address width.
  function automatic int unsigned bank_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // Counter width able to hold 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned addr_size);
    return addr_size + 32'd1;
  endfunction

endpackage

// File: rtl/pp_sync_bit.sv
// Multi-flop synchroniser for a single level signal; resets to 1 so an
// empty flag reads as "empty" until the read domain says otherwise.
module pp_sync_bit #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  // Shift the asynchronous input one stage per clock.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  // Chain flops, asynchronously preset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pingpong_wr_sched.sv
// Write-side scheduler for a ping-pong pair of async FIFOs. Steers the
// upstream stream into one bank at a time, seals a bank on a full burst,
// a flush, or an unexpected full flag, and holds upstream off while the
// next target bank is still being drained by the reader.
module pingpong_wr_sched
  import pingpong_pkg::*;
#(
  parameter int unsigned DATASIZE    = 8,
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                rst_n,
  input  logic                wr_req,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                flush,
  input  logic                wfull_0,
  input  logic                wfull_1,
  input  logic                rempty_0,
  input  logic                rempty_1,
  output logic                winc_0,
  output logic                winc_1,
  output logic [DATASIZE-1:0] wdata_o,
  output logic                w_stop,
  output logic                wbank,
  output logic                bank_ready_0,
  output logic                bank_ready_1,
  output logic [ADDRSIZE:0]   bank_len_0,
  output logic [ADDRSIZE:0]   bank_len_1,
  output logic                err_early_full
);

  localparam int unsigned Depth = bank_depth(ADDRSIZE);
  localparam int unsigned CntW  = cnt_width(ADDRSIZE);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  // Per-bank state
  bank_state_e     state_q [NumBanks];
  bank_state_e     state_d [NumBanks];
  logic [CntW-1:0] cnt_q   [NumBanks];
  logic [CntW-1:0] cnt_d   [NumBanks];
  logic [CntW-1:0] len_q   [NumBanks];
  logic [CntW-1:0] len_d   [NumBanks];

  logic wbank_q, wbank_d;
  logic err_q, err_d;

  logic [NumBanks-1:0] empty_sync;
  logic [NumBanks-1:0] wfull_vec;

  bank_state_e     tgt_state;
  logic            stop;
  logic            accept;
  logic [CntW-1:0] cnt_inc;
  logic            seal_full;
  logic            seal_flush;
  logic            seal_early;
  logic            seal;

  assign wfull_vec = {wfull_1, wfull_0};

  // Bring the reader's empty flags into the write clock domain.
  pp_sync_bit #(
    .Stages (SYNC_STAGES)
  ) u_sync_empty_0 (
    .clk_i  (wclk),
    .rst_ni (rst_n),
    .d_i    (rempty_0),
    .q_o    (empty_sync[0])
  );

  pp_sync_bit #(
    .Stages (SYNC_STAGES)
  ) u_sync_empty_1 (
    .clk_i  (wclk),
    .rst_ni (rst_n),
    .d_i    (rempty_1),
    .q_o    (empty_sync[1])
  );

  // Accept decision and seal detection for the currently targeted bank.
  always_comb begin
    tgt_state = state_q[wbank_q];
    stop      = !((tgt_state == BankFree) || (tgt_state == BankFilling));
    accept    = wr_req && !stop;
    // Count including this cycle's word, so a same-cycle flush sees it.
    cnt_inc   = cnt_q[wbank_q] + {{(CntW-1){1'b0}}, accept};

    seal_full  = accept && (cnt_inc == DepthCnt);
    seal_flush = flush && !stop && (cnt_inc != '0);
    // FIFO claims full although we have not yet written a whole burst.
    seal_early = (tgt_state == BankFilling) && wfull_vec[wbank_q] && (cnt_inc < DepthCnt);
    seal       = seal_full || seal_flush || seal_early;
  end

  // Next-state: release path for every bank, fill/seal path for the target.
  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      len_d[b]   = len_q[b];
      // Two-step release: a stale synced "empty" can linger right after the
      // seal, so the flag must be seen low before a high counts as drained.
      case (state_q[b])
        BankSealedNe: if (!empty_sync[b]) state_d[b] = BankSealed;
        BankSealed:   if (empty_sync[b])  state_d[b] = BankFree;
        default:      ;
      endcase
    end
    wbank_d = wbank_q;
    err_d   = err_q;

    if (accept) begin
      cnt_d[wbank_q] = cnt_inc;
      if (tgt_state == BankFree) begin
        state_d[wbank_q] = BankFilling;
      end
    end

    if (seal) begin
      len_d[wbank_q]   = cnt_inc;
      cnt_d[wbank_q]   = '0;
      state_d[wbank_q] = BankSealedNe;
      wbank_d          = ~wbank_q;
    end

    if (seal_early) begin
      err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NumBanks; b++) begin
        state_q[b] <= BankFree;
        cnt_q[b]   <= '0;
        len_q[b]   <= '0;
      end
      wbank_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
        len_q[b]   <= len_d[b];
      end
      wbank_q <= wbank_d;
      err_q   <= err_d;
    end
  end

  // Outputs: strobes are combinational so a word is written the cycle it is offered.
  always_comb begin
    winc_0         = accept && !wbank_q;
    winc_1         = accept && wbank_q;
    wdata_o        = wdata;
    w_stop         = stop;
    wbank          = wbank_q;
    bank_ready_0   = (state_q[0] == BankSealedNe) || (state_q[0] == BankSealed);
    bank_ready_1   = (state_q[1] == BankSealedNe) || (state_q[1] == BankSealed);
    bank_len_0     = len_q[0];
    bank_len_1     = len_q[1];
    err_early_full = err_q;
  end

endmodule

// File: tb/tb_pingpong_wr_sched.sv
// Directed bench for pingpong_wr_sched (DEPTH = 16, two-stage empty sync).
module tb_pingpong_wr_sched;

  localparam int unsigned DS = 8;
  localparam int unsigned AS = 4;

  logic          wclk;
  logic          rst_n;
  logic          wr_req;
  logic [DS-1:0] wdata;
  logic          flush;
  logic          wfull_0, wfull_1;
  logic          rempty_0, rempty_1;
  logic          winc_0, winc_1;
  logic [DS-1:0] wdata_o;
  logic          w_stop;
  logic          wbank;
  logic          bank_ready_0, bank_ready_1;
  logic [AS:0]   bank_len_0, bank_len_1;
  logic          err_early_full;

  int n_checks = 0;
  int n_fail   = 0;

  pingpong_wr_sched #(
    .DATASIZE    (DS),
    .ADDRSIZE    (AS),
    .SYNC_STAGES (2)
  ) dut (
    .wclk           (wclk),
    .rst_n          (rst_n),
    .wr_req         (wr_req),
    .wdata          (wdata),
    .flush          (flush),
    .wfull_0        (wfull_0),
    .wfull_1        (wfull_1),
    .rempty_0       (rempty_0),
    .rempty_1       (rempty_1),
    .winc_0         (winc_0),
    .winc_1         (winc_1),
    .wdata_o        (wdata_o),
    .w_stop         (w_stop),
    .wbank          (wbank),
    .bank_ready_0   (bank_ready_0),
    .bank_ready_1   (bank_ready_1),
    .bank_len_0     (bank_len_0),
    .bank_len_1     (bank_len_1),
    .err_early_full (err_early_full)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_req = 1'b0; wdata = '0; flush = 1'b0;
    wfull_0 = 1'b0; wfull_1 = 1'b0; rempty_0 = 1'b1; rempty_1 = 1'b1;
    tick(); tick();
    n_checks++;
    if ({wbank, w_stop, bank_ready_0, bank_ready_1, err_early_full, winc_0, winc_1} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got wbank/stop/rdy0/rdy1/err/winc0/winc1=%b want 0000000",
               {wbank, w_stop, bank_ready_0, bank_ready_1, err_early_full, winc_0, winc_1});
    end
    n_checks++;
    if (bank_len_0 !== 5'd0 || bank_len_1 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_len: got len0=%0d len1=%0d want 0 0", bank_len_0, bank_len_1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Words 0..31 stream through bank 0 then bank 1 with no stall in between.
  task automatic test_fill_two_banks();
    logic [1:0] exp_inc;
    wr_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wdata   = DS'(i);
      exp_inc = (i >= 16) ? 2'b10 : 2'b01;
      #1;
      n_checks++;
      if ({winc_1, winc_0} !== exp_inc || wdata_o !== DS'(i) || w_stop !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_word%0d: got winc1/0=%b data=%0d stop=%b want %b %0d 0",
                 i, {winc_1, winc_0}, wdata_o, w_stop, exp_inc, i);
      end
      tick();
      if (i == 15) begin
        n_checks++;
        if (bank_ready_0 !== 1'b1 || bank_len_0 !== 5'd16 || wbank !== 1'b1) begin
          n_fail++;
          $display("FAIL seal_bank0: got rdy0=%b len0=%0d wbank=%b want 1 16 1",
                   bank_ready_0, bank_len_0, wbank);
        end
      end
    end
    n_checks++;
    if (bank_ready_1 !== 1'b1 || bank_len_1 !== 5'd16 || wbank !== 1'b0 || w_stop !== 1'b1) begin
      n_fail++;
      $display("FAIL seal_bank1: got rdy1=%b len1=%0d wbank=%b stop=%b want 1 16 0 1",
               bank_ready_1, bank_len_1, wbank, w_stop);
    end
  endtask

  // Reader stopped: word 32 is held and nothing is strobed.
  task automatic test_stall();
    wdata = 8'd32;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (winc_0 !== 1'b0 || winc_1 !== 1'b0 || w_stop !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: got winc0=%b winc1=%b stop=%b want 0 0 1",
                 k, winc_0, winc_1, w_stop);
      end
      tick();
    end
  endtask

  // Reader drains bank 0: empty goes 0 then 1; release lands 3 edges after the rise.
  task automatic test_drain_release();
    rempty_0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (w_stop !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_low_cyc%0d: got stop=%b want 1", k, w_stop);
      end
      tick();
    end
    rempty_0 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (w_stop !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_sync_edge%0d: got stop=%b want 1", k + 1, w_stop);
      end
    end
    tick();
    n_checks++;
    if (w_stop !== 1'b0 || winc_0 !== 1'b1 || winc_1 !== 1'b0 || wdata_o !== 8'd32
        || bank_ready_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_release: got stop=%b winc0=%b winc1=%b data=%0d rdy0=%b want 0 1 0 32 0",
               w_stop, winc_0, winc_1, wdata_o, bank_ready_0);
    end
    tick();
  endtask

  // Words 33..36 join word 32 in bank 0, then a lone flush seals at 5.
  task automatic test_flush_partial();
    for (int i = 33; i < 37; i++) begin
      wdata = DS'(i);
      #1;
      n_checks++;
      if (winc_0 !== 1'b1 || winc_1 !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_word%0d: got winc0=%b winc1=%b want 1 0", i, winc_0, winc_1);
      end
      tick();
    end
    wr_req = 1'b0;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    n_checks++;
    if (bank_len_0 !== 5'd5 || bank_ready_0 !== 1'b1 || wbank !== 1'b1 || w_stop !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_partial: got len0=%0d rdy0=%b wbank=%b stop=%b want 5 1 1 1",
               bank_len_0, bank_ready_0, wbank, w_stop);
    end
  endtask

  // Reader drains bank b; the bank must come back as not ready.
  task automatic drain_bank(input int b);
    if (b == 0) rempty_0 = 1'b0; else rempty_1 = 1'b0;
    repeat (3) tick();
    if (b == 0) rempty_0 = 1'b1; else rempty_1 = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ((b == 0 ? bank_ready_0 : bank_ready_1) !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_bank%0d: got ready=%b want 0", b,
               (b == 0 ? bank_ready_0 : bank_ready_1));
    end
  endtask

  // Flush coincident with the 16th word seals once; flush at count 0 is a no-op.
  task automatic test_flush_with_last();
    drain_bank(1);
    wr_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = DS'(50 + i);
      flush = (i == 15);
      #1;
      n_checks++;
      if (winc_1 !== 1'b1 || winc_0 !== 1'b0) begin
        n_fail++;
        $display("FAIL last_word%0d: got winc1=%b winc0=%b want 1 0", i, winc_1, winc_0);
      end
      tick();
    end
    wr_req = 1'b0;
    flush  = 1'b0;
    n_checks++;
    if (bank_len_1 !== 5'd16 || bank_ready_1 !== 1'b1 || wbank !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_last: got len1=%0d rdy1=%b wbank=%b want 16 1 0",
               bank_len_1, bank_ready_1, wbank);
    end
    tick();
    n_checks++;
    if (wbank !== 1'b0 || w_stop !== 1'b1 || bank_ready_0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_seal: got wbank=%b stop=%b rdy0=%b want 0 1 1",
               wbank, w_stop, bank_ready_0);
    end
    drain_bank(0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++;
    if (wbank !== 1'b0 || w_stop !== 1'b0 || bank_ready_0 !== 1'b0 || bank_len_0 !== 5'd5) begin
      n_fail++;
      $display("FAIL flush_empty: got wbank=%b stop=%b rdy0=%b len0=%0d want 0 0 0 5",
               wbank, w_stop, bank_ready_0, bank_len_0);
    end
  endtask

  // FIFO 0 reports full at 9 words: early seal and sticky error.
  task automatic test_early_full();
    wr_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wdata = DS'(100 + i);
      tick();
    end
    wr_req  = 1'b0;
    n_checks++;
    if (err_early_full !== 1'b0 || bank_ready_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL early_pre: got err=%b rdy0=%b want 0 0", err_early_full, bank_ready_0);
    end
    wfull_0 = 1'b1;
    tick();
    wfull_0 = 1'b0;
    n_checks++;
    if (bank_len_0 !== 5'd9 || err_early_full !== 1'b1 || bank_ready_0 !== 1'b1 || wbank !== 1'b1) begin
      n_fail++;
      $display("FAIL early_full: got len0=%0d err=%b rdy0=%b wbank=%b want 9 1 1 1",
               bank_len_0, err_early_full, bank_ready_0, wbank);
    end
    tick();
    n_checks++;
    if (err_early_full !== 1'b1) begin
      n_fail++;
      $display("FAIL early_sticky: got err=%b want 1", err_early_full);
    end
  endtask

  // Reset asserted mid-fill takes effect immediately.
  task automatic test_reset_mid();
    drain_bank(1);
    wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = DS'(200 + i);
      tick();
    end
    wr_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_checks++;
    if ({wbank, w_stop, bank_ready_0, bank_ready_1, err_early_full} !== 5'b0
        || bank_len_0 !== 5'd0 || bank_len_1 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got wbank/stop/rdy0/rdy1/err=%b len0=%0d len1=%0d want 00000 0 0",
               {wbank, w_stop, bank_ready_0, bank_ready_1, err_early_full},
               bank_len_0, bank_len_1);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Counter must have cleared: a full burst seals exactly at 16.
    wr_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata = DS'(i);
      tick();
    end
    wr_req = 1'b0;
    n_checks++;
    if (bank_len_0 !== 5'd16 || wbank !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_count: got len0=%0d wbank=%b want 16 1", bank_len_0, wbank);
    end
  endtask

  initial begin
    test_reset();
    test_fill_two_banks();
    test_stall();
    test_drain_release();
    test_flush_partial();
    test_flush_with_last();
    test_early_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop guard so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test want finish");
    $fatal(1, "timeout");
  end

endmodule
